// File: rtl/fp_mult_arbiter.sv
// Round-robin front end for a shared double-precision multiplier core.
// Accepts one operation at a time from NREQ requesters, issues it to the core
// with a one-cycle start pulse, waits for completion under a watchdog, and
// returns the 64-bit product tagged with the owning requester index.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   req_valid/req_ready       per-requester request / one-hot accept (comb)
//   req_a/req_b               packed operands, requester i at [64i+63:64i]
//   resp_valid/resp_ready     result handshake
//   resp_id/resp_result       owner index and product (qNaN on timeout)
//   resp_timeout              result came from a watchdog abort
//   mul_start/mul_a/mul_b     start pulse and held operands to the core
//   mul_done/mul_result       completion pulse and product from the core
//   busy                      high whenever an operation is in flight
module fp_mult_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CW      = 9
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [64*NREQ-1:0]   req_a,
   input  logic [64*NREQ-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [63:0]          resp_result,
   output logic                 resp_timeout,
   output logic                 mul_start,
   output logic [63:0]          mul_a,
   output logic [63:0]          mul_b,
   input  logic                 mul_done,
   input  logic [63:0]          mul_result,
   output logic                 busy
);

   localparam int unsigned DW       = 64;
   localparam logic [DW-1:0] QNAN   = 64'h7FF8000000000000;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  id_q;
   logic [CW-1:0]   cnt_q;
   logic            mul_start_q;
   logic            resp_valid_q;
   logic            resp_timeout_q;
   logic            busy_q;
   logic [DW-1:0]   mul_a_q;
   logic [DW-1:0]   mul_b_q;
   logic [DW-1:0]   resp_result_q;

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  ptr_d;
   logic [DW-1:0]   a_sel;
   logic [DW-1:0]   b_sel;
   logic            accept;

   // First active requester scanning upward from the pointer, with wrap
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!grant_found && req_valid[IDW'((32'(ptr_q) + k) % NREQ)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'((32'(ptr_q) + k) % NREQ);
         end
      end
   end

   // Operand mux for the winning requester
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            a_sel = req_a[i*DW +: DW];
            b_sel = req_b[i*DW +: DW];
         end
      end
   end

   assign ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
   assign accept = (state_q == S_IDLE) && grant_found;

   // Accept is combinational so the handshake closes in the grant cycle
   assign req_ready = (accept && reset_n) ? (NREQ'(1) << grant_idx) : '0;

   // Operation sequencer: accept, start pulse, watchdog wait, response hold
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         id_q           <= '0;
         cnt_q          <= '0;
         mul_start_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         busy_q         <= 1'b0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         resp_result_q  <= '0;
      end else begin
         mul_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mul_a_q     <= a_sel;
                  mul_b_q     <= b_sel;
                  id_q        <= grant_idx;
                  ptr_q       <= ptr_d;
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // A completion in the final watchdog cycle takes priority
               if (mul_done) begin
                  resp_result_q  <= mul_result;
                  resp_timeout_q <= 1'b0;
                  resp_valid_q   <= 1'b1;
                  state_q        <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  resp_result_q  <= QNAN;
                  resp_timeout_q <= 1'b1;
                  resp_valid_q   <= 1'b1;
                  state_q        <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mul_start    = mul_start_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign resp_valid   = resp_valid_q;
   assign resp_id      = id_q;
   assign resp_result  = resp_result_q;
   assign resp_timeout = resp_timeout_q;
   assign busy         = busy_q;

endmodule
